fc_s3: RTL

//  Stage 3: fully-connected classifier layer, directly downstream of etapa2.

---
 rtl/fc_s3.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fc_s3.sv
// Fully-connected classifier stage: one sequential MAC computes N_OUT neurons
// (bias + N_IN-term dot product from an external weight BRAM) and tracks the argmax.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_BIAS  | request bias(k) from the weight BRAM
// S_MAC   | request weight(k,i); accumulate the previous word (first word is the bias)
// S_DRAIN | fold in the final product, write fc_out[k]
// S_STORE | update running max / class index, advance k
// S_DONE  | one-cycle done pulse
module fc_s3 #(
   parameter int N_IN   = 144,
   parameter int N_OUT  = 10,
   parameter int IN_W   = 35,
   parameter int W_W    = 17,
   parameter int ACC_W  = 60,
   parameter int ADDR_W = 11
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [N_IN*IN_W-1:0]     i_s2_in,
   output logic                     o_weight_en,
   output logic [ADDR_W-1:0]        o_weight_addr,
   input  logic [W_W-1:0]           i_weight_data,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [N_OUT*ACC_W-1:0]   o_fc_out,
   output logic [3:0]               o_class_idx
);

   localparam int P_W       = IN_W + W_W;
   localparam int BIAS_BASE = N_IN * N_OUT;
   localparam logic [7:0] I_LAST = 8'(N_IN - 1);
   localparam logic [3:0] K_LAST = 4'(N_OUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_STORE, S_DONE} state_t;

   state_t r_state, w_next;

   logic [7:0]              r_i;
   logic [3:0]              r_k;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_max;
   logic signed [ACC_W-1:0] r_fc [N_OUT];
   logic [3:0]              r_class;

   logic [7:0]              w_idx;
   logic signed [IN_W-1:0]  w_x;
   logic signed [W_W-1:0]   w_w;
   logic signed [P_W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_bias_ext;

   // The BRAM word arriving now belongs to the address issued one cycle earlier.
   assign w_idx      = (r_i == 8'd0) ? 8'd0 : r_i - 8'd1;
   assign w_x        = $signed(i_s2_in[w_idx*IN_W +: IN_W]);
   assign w_w        = $signed(i_weight_data);
   assign w_prod     = w_x * w_w;
   assign w_sum      = r_acc + {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
   assign w_bias_ext = {{(ACC_W-W_W){i_weight_data[W_W-1]}}, i_weight_data};

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      o_weight_en   = 1'b0;
      o_weight_addr = '0;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_BIAS;
         S_BIAS: begin
            o_weight_en   = 1'b1;
            o_weight_addr = ADDR_W'(BIAS_BASE + int'(r_k));
            w_next        = S_MAC;
         end
         S_MAC: begin
            o_weight_en   = 1'b1;
            o_weight_addr = ADDR_W'(int'(r_k) * N_IN + int'(r_i));
            if (r_i == I_LAST) w_next = S_DRAIN;
         end
         S_DRAIN: w_next = S_STORE;
         S_STORE: w_next = (r_k == K_LAST) ? S_DONE : S_BIAS;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = (r_state == S_DONE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_i     <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_max   <= '0;
         r_class <= '0;
         for (int n = 0; n < N_OUT; n++) r_fc[n] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_k     <= '0;
               r_max   <= '0;
               r_class <= '0;
            end
            S_BIAS: r_i <= '0;
            S_MAC: begin
               r_i   <= r_i + 8'd1;
               r_acc <= (r_i == 8'd0) ? w_bias_ext : w_sum;
            end
            S_DRAIN: begin
               r_acc      <= w_sum;
               r_fc[r_k]  <= w_sum;
            end
            S_STORE: begin
               // strict compare: ties keep the earlier class
               if (r_k == 4'd0 || r_acc > r_max) begin
                  r_max   <= r_acc;
                  r_class <= r_k;
               end
               if (r_k != K_LAST) r_k <= r_k + 4'd1;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign o_fc_out[g*ACC_W +: ACC_W] = r_fc[g];
   end

   assign o_class_idx = r_class;

endmodule
